// File: rtl/bitwise_pipe.sv
// Two-stage valid/ready pipeline applying one of eight bitwise functions to a pair of operands.
// S1 holds the operands, S2 holds the result and its flags; a saturating counter tracks accepts.
module bitwise_pipe #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic [2:0]         op_in,
    input  logic               in_valid_in,
    output logic               in_ready_out,
    output logic [WIDTH-1:0]   y_out,
    output logic               zero_out,
    output logic               parity_out,
    output logic               ones_out,
    output logic               out_valid_out,
    input  logic               out_ready_in,
    output logic [COUNT_W-1:0] count_out
);

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic               s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               zero_q, zero_d;
    logic               parity_q, parity_d;
    logic               ones_q, ones_d;
    logic               s2_valid_q, s2_valid_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    logic               s2_free;
    logic               in_xfer;
    logic [WIDTH-1:0]   res;

    assign s2_free      = !s2_valid_q || out_ready_in;
    assign in_ready_out = !s1_valid_q || s2_free;
    assign in_xfer      = in_valid_in && in_ready_out;

    always_comb begin
        res = '0;
        unique case (op_q)
            3'd0: res = a_q & b_q;
            3'd1: res = a_q | b_q;
            3'd2: res = a_q ^ b_q;
            3'd3: res = ~(a_q ^ b_q);
            3'd4: res = ~a_q;
            3'd5: res = ~(a_q & b_q);
            3'd6: res = ~(a_q | b_q);
            3'd7: res = a_q;
            default: res = '0;
        endcase
    end

    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        s1_valid_d = s1_valid_q;
        y_d        = y_q;
        zero_d     = zero_q;
        parity_d   = parity_q;
        ones_d     = ones_q;
        s2_valid_d = s2_valid_q;
        cnt_d      = cnt_q;

        // S1 captures the operands whenever it can advance, valid or not.
        if (in_ready_out) begin
            a_d        = a_in;
            b_d        = b_in;
            op_d       = op_in;
            s1_valid_d = in_valid_in;
        end

        if (s2_free) begin
            y_d        = res;
            zero_d     = (res == '0);
            parity_d   = ^res;
            ones_d     = &res;
            s2_valid_d = s1_valid_q;
        end

        if (in_xfer && (cnt_q != {COUNT_W{1'b1}})) begin
            cnt_d = cnt_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            s1_valid_q <= 1'b0;
            y_q        <= '0;
            zero_q     <= 1'b0;
            parity_q   <= 1'b0;
            ones_q     <= 1'b0;
            s2_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            s1_valid_q <= s1_valid_d;
            y_q        <= y_d;
            zero_q     <= zero_d;
            parity_q   <= parity_d;
            ones_q     <= ones_d;
            s2_valid_q <= s2_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign y_out         = y_q;
    assign zero_out      = zero_q;
    assign parity_out    = parity_q;
    assign ones_out      = ones_q;
    assign out_valid_out = s2_valid_q;
    assign count_out     = cnt_q;

endmodule
